// File: rtl/ucsbece154b_mpfifo.sv
// Multi-port circular FIFO: up to NR_PUSH writes and NR_POP retires per cycle,
// with occupancy count, almost-full flag and a synchronous flush.
// Optional feature macro: FIFO_BYPASS_EN forwards pushes to the read lanes
// when the queue is empty (zero-latency path). Default build has no bypass.
module ucsbece154b_mpfifo #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NR_ENTRIES   = 8,
  parameter int unsigned NR_PUSH      = 2,
  parameter int unsigned NR_POP       = 2,
  parameter int unsigned AFULL_THRESH = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic [NR_PUSH*DATA_WIDTH-1:0]         data_i,
  input  logic [$clog2(NR_PUSH+1)-1:0]          push_cnt_i,
  output logic [$clog2(NR_PUSH+1)-1:0]          push_acc_o,
  output logic [NR_POP*DATA_WIDTH-1:0]          data_o,
  output logic [NR_POP-1:0]                     valid_o,
  input  logic [$clog2(NR_POP+1)-1:0]           pop_cnt_i,
  output logic [$clog2(NR_ENTRIES+1)-1:0]       count_o,
  output logic                                  full_o,
  output logic                                  afull_o
);

  localparam int unsigned CW = $clog2(NR_ENTRIES + 1);
  localparam int unsigned PW = $clog2(NR_PUSH + 1);
  localparam int unsigned IW = $clog2(NR_ENTRIES);
`ifdef FIFO_BYPASS_EN
  localparam int unsigned NBYP = (NR_POP < NR_PUSH) ? NR_POP : NR_PUSH;
`endif

  logic [DATA_WIDTH-1:0] mem_q [NR_ENTRIES];
  logic [IW-1:0]         head_q, head_d;
  logic [IW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  int unsigned push_acc_n;  // lanes accepted this cycle
  int unsigned pop_q_n;     // entries retired from storage
  int unsigned byp_n;       // accepted lanes consumed straight through the bypass
  int unsigned store_n;     // accepted lanes actually written to storage

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // p < NR_ENTRIES and n <= NR_ENTRIES, so a single conditional subtract suffices.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int unsigned n);
    int unsigned s;
    s = 32'(p) + n;
    if (s >= NR_ENTRIES) s = s - NR_ENTRIES;
    return IW'(s);
  endfunction

  // Acceptance, retirement and next-state pointer/count computation.
  always_comb begin
    push_acc_n = min_u(32'(push_cnt_i), NR_ENTRIES - 32'(count_q));
    if (flush_i || rst_i) push_acc_n = 0;
    pop_q_n = min_u(32'(pop_cnt_i), 32'(count_q));
    byp_n   = 0;
`ifdef FIFO_BYPASS_EN
    if (count_q == '0 && !flush_i) byp_n = min_u(32'(pop_cnt_i), push_acc_n);
`endif
    store_n = push_acc_n - byp_n;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = wrap_add(head_q, pop_q_n);
      tail_d  = wrap_add(tail_q, store_n);
      count_d = CW'(32'(count_q) + store_n - pop_q_n);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage write: lanes byp_n..push_acc_n-1 land at consecutive slots from tail.
  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < NR_PUSH; i++) begin
      if (i >= byp_n && i < push_acc_n) begin
        mem_q[wrap_add(tail_q, i - byp_n)] <= data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Read lanes, status flags and accepted-lane count.
  always_comb begin
    for (int unsigned k = 0; k < NR_POP; k++) begin
      data_o[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[wrap_add(head_q, k)];
      valid_o[k] = 32'(count_q) > k;
    end
`ifdef FIFO_BYPASS_EN
    for (int unsigned k = 0; k < NBYP; k++) begin
      if (count_q == '0 && !flush_i && k < push_acc_n) begin
        data_o[k*DATA_WIDTH +: DATA_WIDTH] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
        valid_o[k] = 1'b1;
      end
    end
`endif
    push_acc_o = PW'(push_acc_n);
    count_o    = count_q;
    full_o     = 32'(count_q) == NR_ENTRIES;
    afull_o    = (NR_ENTRIES - 32'(count_q)) <= AFULL_THRESH;
  end

endmodule

// File: tb/tb_ucsbece154b_mpfifo.sv
// Directed bench for ucsbece154b_mpfifo: depth-8 instance for reset, push/pop,
// full, flush and latency/bypass; depth-6 instance for pointer wrap.
module tb_ucsbece154b_mpfifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Depth-8 instance
  logic        flush;
  logic [63:0] din;
  logic [1:0]  push_cnt, push_acc, pop_cnt;
  logic [63:0] dout;
  logic [1:0]  valid;
  logic [3:0]  count;
  logic        full, afull;

  // Depth-6 instance
  logic [63:0] din6;
  logic [1:0]  push_cnt6, push_acc6, pop_cnt6;
  logic [63:0] dout6;
  logic [1:0]  valid6;
  logic [2:0]  count6;
  logic        full6, afull6;

  ucsbece154b_mpfifo dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .push_cnt_i(push_cnt),
    .push_acc_o(push_acc), .data_o(dout), .valid_o(valid), .pop_cnt_i(pop_cnt),
    .count_o(count), .full_o(full), .afull_o(afull)
  );

  ucsbece154b_mpfifo #(.NR_ENTRIES(6)) dut6 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0), .data_i(din6), .push_cnt_i(push_cnt6),
    .push_acc_o(push_acc6), .data_o(dout6), .valid_o(valid6), .pop_cnt_i(pop_cnt6),
    .count_o(count6), .full_o(full6), .afull_o(afull6)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] pc, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] qc);
    push_cnt = pc;
    din      = {b, a};
    pop_cnt  = qc;
  endtask

  int seq_in, seq_out;

  initial begin
    flush = 0; din = '0; push_cnt = 0; pop_cnt = 0;
    din6 = '0; push_cnt6 = 0; pop_cnt6 = 0;

    // T1 reset
    #3;
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    check("rst_afull", 64'(afull), 64'd0);
    check("rst_push_acc", 64'(push_acc), 64'd0);
    #9 rst = 0;
    tick();

    // T2 dual push, then dual pop
    drive(2, 32'hA, 32'hB, 0);
    #1 check("t2_push_acc", 64'(push_acc), 64'd2);
    tick();
    drive(0, 0, 0, 2);
    #1;
    check("t2_valid", 64'(valid), 64'd3);
    check("t2_count", 64'(count), 64'd2);
    check("t2_data", dout, {32'hB, 32'hA});
    check("t2_afull", 64'(afull), 64'd0);
    tick();
    drive(0, 0, 0, 0);
    #1;
    check("t2_count_after_pop", 64'(count), 64'd0);
    check("t2_valid_after_pop", 64'(valid), 64'd0);

    // T3 fill to 7, then offer 2 with 1 free slot
    drive(2, 32'hC0, 32'hC1, 0); tick();
    drive(2, 32'hC2, 32'hC3, 0); tick();
    drive(2, 32'hC4, 32'hC5, 0); tick();
    drive(1, 32'hC6, 32'hEE, 0); tick();
    drive(2, 32'hD0, 32'hD1, 0);
    #1;
    check("t3_count7", 64'(count), 64'd7);
    check("t3_afull7", 64'(afull), 64'd1);
    check("t3_full7", 64'(full), 64'd0);
    check("t3_push_acc", 64'(push_acc), 64'd1);
    tick();
    drive(2, 32'hF0, 32'hF1, 0);
    #1;
    check("t3_count8", 64'(count), 64'd8);
    check("t3_full8", 64'(full), 64'd1);
    check("t3_afull8", 64'(afull), 64'd1);
    check("t3_push_acc_full", 64'(push_acc), 64'd0);
    tick();
    drive(0, 0, 0, 2); #1;
    check("t3_pop0", dout, {32'hC1, 32'hC0}); tick(); #1;
    check("t3_pop1", dout, {32'hC3, 32'hC2}); tick(); #1;
    check("t3_pop2", dout, {32'hC5, 32'hC4}); tick(); #1;
    check("t3_pop3", dout, {32'hD0, 32'hC6});
    check("t3_count_tail", 64'(count), 64'd2);
    tick();
    drive(0, 0, 0, 0); #1;
    check("t3_drained", 64'(count), 64'd0);

    // T5 flush with concurrent push and pop
    drive(2, 1, 2, 0); tick();
    drive(2, 3, 4, 0); tick();
    drive(1, 5, 0, 0); tick();
    drive(2, 6, 7, 1);
    flush = 1;
    #1;
    check("t5_count5", 64'(count), 64'd5);
    check("t5_afull5", 64'(afull), 64'd0);
    check("t5_push_acc_flush", 64'(push_acc), 64'd0);
    tick();
    flush = 0;
    drive(1, 32'hE, 0, 0);
    #1;
    check("t5_count", 64'(count), 64'd0);
    check("t5_valid", 64'(valid), 64'd0);
    check("t5_push_acc_after", 64'(push_acc), 64'd1);
    tick();
    drive(0, 0, 0, 1);
    #1;
    check("t5_post_flush_data", 64'(dout[31:0]), 64'hE);
    check("t5_post_flush_valid", 64'(valid), 64'd1);
    tick();
    drive(0, 0, 0, 0);
    #1 check("t5_empty", 64'(count), 64'd0);

    // T6 push and pop the same entry on an empty queue
    drive(1, 32'h5A, 0, 1);
    #1;
`ifdef FIFO_BYPASS_EN
    check("t6_byp_valid", 64'(valid[0]), 64'd1);
    check("t6_byp_data", 64'(dout[31:0]), 64'h5A);
    tick();
    drive(0, 0, 0, 0);
    #1 check("t6_byp_count", 64'(count), 64'd0);
`else
    check("t6_nobyp_valid", 64'(valid[0]), 64'd0);
    tick();
    drive(0, 0, 0, 1);
    #1;
    check("t6_late_valid", 64'(valid[0]), 64'd1);
    check("t6_late_data", 64'(dout[31:0]), 64'h5A);
    check("t6_late_count", 64'(count), 64'd1);
    tick();
    drive(0, 0, 0, 0);
    #1 check("t6_drained", 64'(count), 64'd0);
`endif

    // T4 wrap on depth 6: steady two-in/two-out stream
    seq_in = 0;
    seq_out = 0;
    din6 = {32'(100 + seq_in + 1), 32'(100 + seq_in)};
    push_cnt6 = 2;
    seq_in += 2;
    tick();
    for (int c = 0; c < 10; c++) begin
      din6 = {32'(100 + seq_in + 1), 32'(100 + seq_in)};
      push_cnt6 = 2;
      pop_cnt6 = 2;
      seq_in += 2;
      #1;
      check("t4_data", dout6, {32'(100 + seq_out + 1), 32'(100 + seq_out)});
      check("t4_count", 64'(count6), 64'd2);
      check("t4_push_acc", 64'(push_acc6), 64'd2);
      seq_out += 2;
      tick();
    end
    push_cnt6 = 0;
    pop_cnt6 = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
